// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared definitions for the req/rw shared-bus initiator and responder
package bus_pkg;

    localparam int BUS_DATA_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with saturating occupancy count
module sync_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - shared-bus target: writes fill the RX FIFO, reads drain the TX FIFO
module bus_responder
    import bus_pkg::*;
#(
    parameter int                 DATA_W    = BUS_DATA_W,
    parameter int                 DEPTH     = 4,
    parameter logic [DATA_W-1:0]  EMPTY_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    rw,
    inout  wire  [DATA_W-1:0]       data_bus,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_push,
    output logic                    tx_full,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    input  logic                    rx_pop,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic                    ovf,
    output logic                    unf,
    input  logic                    clr_err
);

    bus_state_e        state_q, state_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;
    logic              rx_push, tx_pop;
    logic              rx_full, rx_empty, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              drive_en;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (data_bus),
        .pop   (rx_pop),
        .head  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign rx_valid = !rx_empty;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // Drive is combinational so read data appears in the cycle req rises and drops with reset.
    assign drive_en = rst && req && (rw == RW_READ) && (state_q != WR);
    assign data_bus = drive_en ? (tx_empty ? EMPTY_VAL : tx_head) : {DATA_W{1'bz}};

    always_comb begin
        state_d = state_q;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (rw == RW_WRITE) begin
                        rx_push = 1'b1;
                        ovf_set = rx_full;
                        state_d = WR;
                    end else begin
                        unf_set = tx_empty;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                // The TX head is held for the whole pulse and retired once req drops.
                if (!req) begin
                    tx_pop  = !tx_empty;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d = clr_err ? 1'b0 : (ovf_q | ovf_set);
        unf_d = clr_err ? 1'b0 : (unf_q | unf_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder against a queue-based model
module tb_bus_responder;

    localparam int         DEPTH    = 4;
    localparam logic [3:0] EV       = 4'h0;
    localparam logic [3:0] IDLE_BUS = 4'hF;

    logic       clk = 1'b0;
    logic       rst, req, rw, tx_push, rx_pop, clr_err, bus_en;
    logic [3:0] tx_data, bus_drv;
    wire  [3:0] data_bus;
    wire        tx_full, rx_valid, ovf, unf;
    wire  [2:0] tx_count, rx_count;
    wire  [3:0] rx_data;

    int errors = 0;
    int checks = 0;

    logic [3:0] tx_m[$];
    logic [3:0] rx_m[$];
    bit         ovf_m, unf_m;

    assign data_bus = bus_en ? bus_drv : 4'bzzzz;
    pullup (data_bus[0]);
    pullup (data_bus[1]);
    pullup (data_bus[2]);
    pullup (data_bus[3]);

    always #5 clk = ~clk;

    bus_responder #(.DATA_W(4), .DEPTH(DEPTH), .EMPTY_VAL(EV)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rw       (rw),
        .data_bus (data_bus),
        .tx_data  (tx_data),
        .tx_push  (tx_push),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_pop   (rx_pop),
        .rx_count (rx_count),
        .ovf      (ovf),
        .unf      (unf),
        .clr_err  (clr_err)
    );

    task automatic do_write(input logic [3:0] v, input int len, input bit pop, output bit drove);
        bit was_full;
        drove = 1'b0;
        @(posedge clk); #1 req = 1'b1; rw = 1'b0; bus_en = 1'b1; bus_drv = v; rx_pop = pop;
        @(posedge clk); #1 rx_pop = 1'b0; bus_en = 1'b0;
        @(negedge clk); if (data_bus !== IDLE_BUS) drove = 1'b1;
        for (int i = 1; i < len; i++) begin
            @(negedge clk); if (data_bus !== IDLE_BUS) drove = 1'b1;
        end
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        was_full = (rx_m.size() == DEPTH);
        if (pop && rx_m.size() > 0) void'(rx_m.pop_front());
        if (was_full) ovf_m = 1'b1;
        else rx_m.push_back(v);
    endtask

    task automatic do_read(input int len, output logic [3:0] first, output bit stable);
        @(posedge clk); #1 req = 1'b1; rw = 1'b1;
        @(negedge clk); first = data_bus; stable = 1'b1;
        for (int i = 1; i < len; i++) begin
            @(negedge clk); if (data_bus !== first) stable = 1'b0;
        end
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        if (tx_m.size() == 0) unf_m = 1'b1;
        else void'(tx_m.pop_front());
    endtask

    task automatic push_tx(input logic [3:0] v);
        @(posedge clk); #1 tx_push = 1'b1; tx_data = v;
        @(posedge clk); #1 tx_push = 1'b0;
        if (tx_m.size() < DEPTH) tx_m.push_back(v);
    endtask

    task automatic pop_rx();
        @(posedge clk); #1 rx_pop = 1'b1;
        @(posedge clk); #1 rx_pop = 1'b0;
        if (rx_m.size() > 0) void'(rx_m.pop_front());
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({tx_full, tx_count, rx_valid, rx_count, rx_data, ovf, unf} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {tx_full, tx_count, rx_valid, rx_count, rx_data, ovf, unf});
        end
        checks++;
        if (data_bus !== IDLE_BUS) begin
            errors++;
            $display("FAIL reset_bus: got %h want %h (released)", data_bus, IDLE_BUS);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_write();
        @(posedge clk); #1 req = 1'b1; rw = 1'b0; bus_en = 1'b1; bus_drv = 4'hA;
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_pre_valid: got %b want 0", rx_valid);
        end
        @(posedge clk); #1 bus_en = 1'b0;
        checks++;
        if ({rx_valid, rx_data, rx_count} !== {1'b1, 4'hA, 3'd1}) begin
            errors++;
            $display("FAIL write_capture: got valid=%b data=%h count=%0d want 1 a 1", rx_valid, rx_data, rx_count);
        end
        @(negedge clk);
        checks++;
        if (data_bus !== IDLE_BUS) begin
            errors++;
            $display("FAIL write_no_drive: got %h want %h", data_bus, IDLE_BUS);
        end
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        rx_m.push_back(4'hA);
    endtask

    task automatic test_read_order();
        logic [3:0] f;
        bit s;
        push_tx(4'h3);
        push_tx(4'h7);
        do_read(2, f, s);
        checks++;
        if (f !== 4'h3 || !s) begin
            errors++;
            $display("FAIL read_first: got %h stable=%b want 3 stable=1", f, s);
        end
        do_read(1, f, s);
        checks++;
        if (f !== 4'h7) begin
            errors++;
            $display("FAIL read_second: got %h want 7", f);
        end
        checks++;
        if ({tx_count, unf} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL read_order_end: got count=%0d unf=%b want 0 0", tx_count, unf);
        end
        push_tx(4'h5);
        do_read(1, f, s);
        checks++;
        if (f !== 4'h5) begin
            errors++;
            $display("FAIL push_then_read: got %h want 5", f);
        end
    endtask

    task automatic test_read_empty();
        logic [3:0] f;
        bit s;
        do_read(2, f, s);
        checks++;
        if (f !== EV || !s || unf !== 1'b1) begin
            errors++;
            $display("FAIL read_empty: got bus=%h unf=%b want %h 1", f, unf, EV);
        end
        pulse_clr();
        checks++;
        if (unf !== 1'b0) begin
            errors++;
            $display("FAIL clr_unf: got %b want 0", unf);
        end
    endtask

    task automatic test_overflow();
        bit d;
        while (rx_m.size() > 0) pop_rx();
        for (int v = 1; v <= 5; v++) do_write(4'(v), 1, 1'b0, d);
        checks++;
        if ({rx_count, ovf} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL overflow: got count=%0d ovf=%b want 4 1", rx_count, ovf);
        end
        for (int v = 1; v <= 4; v++) begin
            checks++;
            if (rx_data !== 4'(v)) begin
                errors++;
                $display("FAIL overflow_drain: got %h want %h", rx_data, 4'(v));
            end
            pop_rx();
        end
        checks++;
        if ({rx_valid, rx_count} !== 4'h0) begin
            errors++;
            $display("FAIL overflow_empty: got valid=%b count=%0d want 0 0", rx_valid, rx_count);
        end
        pulse_clr();
    endtask

    task automatic test_simultaneous();
        bit d;
        do_write(4'h8, 1, 1'b0, d);
        do_write(4'h9, 1, 1'b0, d);
        do_write(4'hC, 1, 1'b1, d);
        checks++;
        if (rx_count !== 3'd2) begin
            errors++;
            $display("FAIL simul_count: got %0d want 2", rx_count);
        end
        checks++;
        if (rx_data !== 4'h9) begin
            errors++;
            $display("FAIL simul_head0: got %h want 9", rx_data);
        end
        pop_rx();
        checks++;
        if (rx_data !== 4'hC) begin
            errors++;
            $display("FAIL simul_head1: got %h want c", rx_data);
        end
        pop_rx();
    endtask

    task automatic test_tx_full();
        logic [3:0] f;
        bit s;
        for (int v = 0; v < 4; v++) push_tx(4'(v + 1));
        push_tx(4'hB);
        checks++;
        if ({tx_full, tx_count} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL tx_full: got full=%b count=%0d want 1 4", tx_full, tx_count);
        end
        @(posedge clk); #1 req = 1'b1; rw = 1'b1;
        @(negedge clk); f = data_bus;
        @(posedge clk); #1 req = 1'b0; tx_push = 1'b1; tx_data = 4'hE;
        @(posedge clk); #1 tx_push = 1'b0;
        void'(tx_m.pop_front());
        checks++;
        if (f !== 4'h1 || tx_count !== 3'd3) begin
            errors++;
            $display("FAIL push_pop_full: got head=%h count=%0d want 1 3", f, tx_count);
        end
        for (int v = 2; v <= 4; v++) begin
            do_read(1, f, s);
            checks++;
            if (f !== 4'(v)) begin
                errors++;
                $display("FAIL tx_full_order: got %h want %h", f, 4'(v));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] f, exp_v;
        bit s, d;
        int op;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: push_tx(4'($urandom_range(0, 14)));
                1: begin
                    do_write(4'($urandom_range(0, 14)), $urandom_range(1, 2), 1'($urandom_range(0, 1)), d);
                    checks++;
                    if (d) begin
                        errors++;
                        $display("FAIL rand_write_drive: got driven want released");
                    end
                end
                2: begin
                    exp_v = (tx_m.size() == 0) ? EV : tx_m[0];
                    do_read($urandom_range(1, 3), f, s);
                    checks++;
                    if (f !== exp_v || !s) begin
                        errors++;
                        $display("FAIL rand_read: got %h stable=%b want %h", f, s, exp_v);
                    end
                end
                3: begin
                    if (rx_m.size() > 0) begin
                        checks++;
                        if (rx_data !== rx_m[0]) begin
                            errors++;
                            $display("FAIL rand_rx_head: got %h want %h", rx_data, rx_m[0]);
                        end
                    end
                    pop_rx();
                end
                default: pulse_clr();
            endcase
            checks++;
            if ({tx_count, rx_count, ovf, unf, rx_valid, tx_full} !==
                {3'(tx_m.size()), 3'(rx_m.size()), ovf_m, unf_m, rx_m.size() != 0, tx_m.size() == DEPTH}) begin
                errors++;
                $display("FAIL rand_state: got tx=%0d rx=%0d ovf=%b unf=%b want tx=%0d rx=%0d ovf=%b unf=%b",
                         tx_count, rx_count, ovf, unf, tx_m.size(), rx_m.size(), ovf_m, unf_m);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit d;
        pulse_clr();
        while (tx_m.size() > 0) begin
            logic [3:0] f;
            bit s;
            do_read(1, f, s);
        end
        push_tx(4'h6);
        do_write(4'h2, 1, 1'b0, d);
        @(posedge clk); #1 req = 1'b1; rw = 1'b1;
        @(negedge clk);
        checks++;
        if (data_bus !== 4'h6) begin
            errors++;
            $display("FAIL mid_read_bus: got %h want 6", data_bus);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (data_bus !== IDLE_BUS) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", data_bus, IDLE_BUS);
        end
        checks++;
        if ({tx_full, tx_count, rx_valid, rx_count, rx_data, ovf, unf} !== 15'h0) begin
            errors++;
            $display("FAIL mid_reset_state: got %h want 0", {tx_full, tx_count, rx_valid, rx_count, rx_data, ovf, unf});
        end
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        tx_m.delete();
        rx_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        do_write(4'hB, 1, 1'b0, d);
        checks++;
        if ({rx_count, rx_data} !== {3'd1, 4'hB}) begin
            errors++;
            $display("FAIL idle_after_reset: got count=%0d data=%h want 1 b", rx_count, rx_data);
        end
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; rw = 1'b0; tx_push = 1'b0; rx_pop = 1'b0;
        clr_err = 1'b0; bus_en = 1'b0; tx_data = 4'h0; bus_drv = 4'h0;
        ovf_m = 1'b0; unf_m = 1'b0;
        test_reset();
        test_write();
        test_read_order();
        test_read_empty();
        test_overflow();
        test_simultaneous();
        test_tx_full();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Target-side endpoint for the req/rw/4-bit shared-bus protocol issued by the bus initiator. It shares the initiator's clock and sits on the same tri-state data bus. Write transactions (rw=0) are captured into an RX FIFO that local logic drains; read transactions (rw=1) are served from a TX FIFO that local logic fills. One FIFO entry moves per req pulse.

## Interface
- DATA_W, 4: data bus and FIFO word width.
- DEPTH, 4: entries per FIFO; must be a power of two, at least 2.
- EMPTY_VAL, 4'h0: value driven on a read when the TX FIFO is empty.

Ports:
- clk  in  1  clock; reset is rst (asynchronous, active-low).
- rst  in  1  asynchronous, active-low reset.
- req  in  1  transfer strobe from initiator; one transaction per high pulse.
- rw  in  1  1 = read (responder drives bus), 0 = write; sampled only while req=1.
- data_bus  inout  DATA_W  shared bus.
- tx_data  in  DATA_W  local word to queue for reads.
- tx_push  in  1  enqueue tx_data.
- tx_full  out  1  TX FIFO full.
- tx_count  out  log2(DEPTH)+1  TX occupancy.
- rx_data  out  DATA_W  head of RX FIFO.
- rx_valid  out  1  RX FIFO non-empty.
- rx_pop  in  1  dequeue RX head.
- rx_count  out  log2(DEPTH)+1  RX occupancy.
- ovf  out  1  sticky: bus write arrived while RX full.
- unf  out  1  sticky: bus read arrived while TX empty.
- clr_err  in  1  synchronous clear of ovf/unf.

## Operation
- FSM states: IDLE, WR, RD.
  - IDLE: if req=1 and rw=0, push data_bus into RX and go to WR. If req=1 and rw=1, go to RD; if TX is empty at that edge, set unf.
  - WR: stay while req=1. On req=0, go to IDLE. No further pushes.
  - RD: stay while req=1. On req=0, pop TX (if non-empty) and go to IDLE.
- Bus drive is combinational. data_bus = (TX empty ? EMPTY_VAL : TX head) when rst=1, req=1, rw=1 and state != WR. Otherwise data_bus is Z.
- The responder never drives the bus when rw=0.
- RX push when RX is full: the word is dropped, ovf is set, and the FSM still enters WR.
- tx_push when TX is full is ignored, even if a pop occurs on the same edge.
- rx_pop when RX is empty is ignored.
- Simultaneous push and pop on the same FIFO when it is not full: both take effect and the count is unchanged.
- Counts saturate at 0 and DEPTH and never wrap. Read/write pointers wrap modulo DEPTH.
- clr_err has priority over a same-cycle set.
- rw changing while req=1 is a protocol violation. State is not re-evaluated until req returns to 0.

## Timing
- Reset (rst=0, asynchronous):
  - FSM to IDLE.
  - Both FIFOs empty, pointers 0.
  - tx_full=0, tx_count=0, rx_valid=0, rx_count=0, rx_data=0, ovf=0, unf=0.
  - data_bus released to Z immediately, including mid-transaction.
- Write latency: data is captured on the first rising edge with req=1. rx_valid and rx_count update one cycle later.
- Read data is valid on the bus in the same cycle req rises and is held stable for the whole pulse. The initiator may sample in any cycle of the pulse.
- The TX head advances on the edge where req is first seen 0. The next read pulse sees the next word.
- Minimum req pulse is 1 cycle. Minimum req-low gap is 1 cycle between back-to-back transactions.
- tx_push followed by a read pulse starting the next cycle returns the pushed word.

## Structure
- Shared package bus_pkg holds:
  - the state enum (IDLE/WR/RD);
  - the DATA_W default;
  - rw encoding constants RW_READ=1, RW_WRITE=0.
  The initiator imports the same package.
- Sub-module sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/count/head) is instantiated twice, for TX and RX.
- Top level contains only the FSM, the sticky flags and the tri-state driver.

## Test plan
- Write: req=1, rw=0, bus=4'hA for 2 cycles -> rx_valid=1 next cycle, rx_data=4'hA, rx_count=1. Responder never drives the bus.
- Read order: tx_push 4'h3 then 4'h7; two read pulses -> bus shows 4'h3 then 4'h7, tx_count ends at 0, unf=0.
- Read when empty: read pulse with TX empty -> bus=EMPTY_VAL (4'h0), unf=1. clr_err -> unf=0.
- Overflow: 5 write pulses of 4'h1..4'h5 with DEPTH=4 and no rx_pop -> rx_count=4, ovf=1. Draining yields 1,2,3,4.
- Simultaneous: RX holds 2 entries; a bus write and rx_pop occur on the same edge -> rx_count stays 2 and FIFO order is preserved.
- Reset mid-read: rst=0 while req=1, rw=1 -> bus goes Z in the same cycle, all counts and flags read 0, FSM is IDLE after release.
